// File: rtl/sr_pulse_gen.sv
// Turns debounced set/clear request edges into one-shot s/r pulses for an external SR flip-flop.
// Optional input debounce filter is enabled by defining SR_PULSE_GEN_DEBOUNCE_EN.
module sr_pulse_gen #(
    parameter int DEB_CYCLES   = 4,
    parameter int PULSE_CYCLES = 3,
    parameter int GUARD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic busy
);

    localparam int CNT_MAX    = (PULSE_CYCLES > GUARD_CYCLES) ? PULSE_CYCLES : GUARD_CYCLES;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int GUARD_LAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        SPULSE,
        RPULSE,
        GUARD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       set_sync;
    logic [1:0]       clr_sync;
    logic [1:0]       raw;
    logic [1:0]       filt;
    logic [1:0]       filt_q;
    logic             set_evt;
    logic             clr_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_sync <= '0;
            clr_sync <= '0;
        end else begin
            set_sync <= {set_sync[0], set_req};
            clr_sync <= {clr_sync[0], clr_req};
        end
    end

    always_comb begin
        raw = {clr_sync[1], set_sync[1]};
    end

`ifdef SR_PULSE_GEN_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [DEB_W-1:0] deb_cnt [2];

    // The filtered value flips on the DEB_CYCLES-th consecutive cycle of disagreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= '0;
            for (int unsigned i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (raw[i] != filt[i]) begin
                    if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                        filt[i]    <= raw[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end
`else
    always_comb begin
        filt = raw;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
        end else begin
            filt_q <= filt;
        end
    end

    always_comb begin
        set_evt = filt[0] & ~filt_q[0];
        clr_evt = filt[1] & ~filt_q[1];
    end

    // Edges seen outside IDLE are consumed by filt_q and never revisited.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            s     <= 1'b0;
            r     <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (set_evt && !q_fb) begin
                        state <= SPULSE;
                        s     <= 1'b1;
                        busy  <= 1'b1;
                    end else if (clr_evt && q_fb) begin
                        state <= RPULSE;
                        r     <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                SPULSE, RPULSE: begin
                    if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                        s   <= 1'b0;
                        r   <= 1'b0;
                        cnt <= '0;
                        if (GUARD_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GUARD;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GUARD: begin
                    if (cnt == CNT_W'(GUARD_LAST)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    s     <= 1'b0;
                    r     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Scoreboard bench for sr_pulse_gen: stimulus queues expected pulses, a monitor checks them.
// Debounce scenarios run only when SR_PULSE_GEN_DEBOUNCE_EN is defined.
module tb_sr_pulse_gen;

    localparam int PULSE = 3;
    localparam int GUARDC = 2;
`ifdef SR_PULSE_GEN_DEBOUNCE_EN
    localparam int DEB = 4;
    localparam int LAT = 3 + DEB;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic q_fb = 1'b0;
    logic s, r, busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        bit is_r;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    sr_pulse_gen #(
`ifdef SR_PULSE_GEN_DEBOUNCE_EN
        .DEB_CYCLES(DEB),
`endif
        .PULSE_CYCLES(PULSE),
        .GUARD_CYCLES(GUARDC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .set_req(set_req),
        .clr_req(clr_req),
        .q_fb(q_fb),
        .s(s),
        .r(r),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input bit is_r, input int at);
        exp_t e;
        e.is_r = is_r;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops one expectation per observed pulse and measures pulse/busy widths.
    logic s_q = 1'b0, r_q = 1'b0, busy_q = 1'b0;
    bit   active = 1'b0;
    int   width = 0;
    int   bw = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_s", int'(s), 0);
            chk("reset_r", int'(r), 0);
            chk("reset_busy", int'(busy), 0);
            s_q = 1'b0; r_q = 1'b0; busy_q = 1'b0;
            active = 1'b0; width = 0; bw = 0;
        end else begin
            if (s && r) chk("s_and_r", 1, 0);
            if ((s && !s_q) || (r && !r_q)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_kind_r", int'(r), int'(e.is_r));
                    chk("pulse_rise_cycle", cyc, e.cyc);
                end
                active = 1'b1;
                width = 0;
            end
            if (busy && !busy_q && !(s || r)) chk("busy_without_pulse", 1, 0);
            if (active) begin
                if (s || r) width++;
                else begin
                    chk("pulse_width", width, PULSE);
                    active = 1'b0;
                end
            end
            if (busy) bw++;
            else if (busy_q) begin
                chk("busy_width", bw, PULSE + GUARDC);
                bw = 0;
            end
            s_q = s; r_q = r; busy_q = busy;
        end
    end

    initial begin
        int n;

        // Reset with both requests asserted.
        rst = 1'b1; set_req = 1'b1; clr_req = 1'b1;
        wait_cyc(4);
        set_req = 1'b0; clr_req = 1'b0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(4);

        // Plain set request, q_fb=0.
        q_fb = 1'b0;
        set_req = 1'b1; n = cyc; expect_pulse(1'b0, n + LAT);
        wait_cyc(LAT + 10);
        set_req = 1'b0;
        wait_cyc(LAT + 4);

        // Simultaneous set and clear: set wins, clear dropped.
        set_req = 1'b1; clr_req = 1'b1; n = cyc; expect_pulse(1'b0, n + LAT);
        wait_cyc(LAT + 12);
        set_req = 1'b0; clr_req = 1'b0;
        wait_cyc(LAT + 4);

        // Redundant set with q_fb=1, then a real clear.
        q_fb = 1'b1;
        set_req = 1'b1;
        wait_cyc(LAT + 6);
        set_req = 1'b0;
        wait_cyc(LAT + 4);
        clr_req = 1'b1; n = cyc; expect_pulse(1'b1, n + LAT);
        wait_cyc(LAT + 10);
        clr_req = 1'b0;
        wait_cyc(LAT + 4);
        q_fb = 1'b0;

        // Second set edge while busy is discarded.
        set_req = 1'b1; n = cyc; expect_pulse(1'b0, n + LAT);
        wait_cyc(2);
        set_req = 1'b0;
        wait_cyc(2);
        set_req = 1'b1;
        wait_cyc(LAT + 10);
        set_req = 1'b0;
        wait_cyc(LAT + 6);

`ifdef SR_PULSE_GEN_DEBOUNCE_EN
        // Glitch shorter than the debounce window, then a held request.
        set_req = 1'b1;
        wait_cyc(3);
        set_req = 1'b0;
        wait_cyc(12);
        set_req = 1'b1; n = cyc; expect_pulse(1'b0, n + 7);
        wait_cyc(10);
        set_req = 1'b0;
        wait_cyc(LAT + 6);
`endif

        // Reset in the second SPULSE cycle drops the pulse for good.
        set_req = 1'b1; n = cyc; expect_pulse(1'b0, n + LAT);
        wait_cyc(LAT + 1);
        #2 rst = 1'b1;
        #1;
        chk("midpulse_reset_s", int'(s), 0);
        chk("midpulse_reset_busy", int'(busy), 0);
        wait_cyc(2);
        set_req = 1'b0;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(LAT + 10);
        chk("after_reset_s", int'(s), 0);
        chk("after_reset_busy", int'(busy), 0);

        // Request held across reset release yields exactly one pulse.
        rst = 1'b1; set_req = 1'b1;
        wait_cyc(3);
        rst = 1'b0; n = cyc; expect_pulse(1'b0, n + LAT);
        wait_cyc(LAT + 12);
        set_req = 1'b0;
        wait_cyc(LAT + 6);

        chk("pending_expectations", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
